// File: rtl/hv_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : hv_duty_ramp
// Purpose  : Soft-start setpoint stage ahead of the HV DA PWM generator.
//            Accepts a requested duty code over valid/ready, clamps it to
//            DUTY_LIMIT, and walks the applied duty toward that target in
//            steps of at most STEP_SIZE, one step every STEP_INTERVAL clocks,
//            only while HV enable is high. Dropping HV enable zeroes the
//            applied duty immediately.
// Ports    :
//   i_clk_50m    - 50 MHz system clock
//   i_rst_n      - asynchronous active-low reset
//   i_hv_en      - HV enable; ramping permitted only while high
//   i_set_valid  - setpoint request valid
//   i_set_duty   - requested duty code (16 bit)
//   o_set_ready  - setpoint accept ready (always 1 after reset)
//   o_duty       - applied duty code to PWM stage (registered)
//   o_duty_valid - one-cycle pulse with every change of o_duty
//   o_ramping    - high in RAMP state
//   o_settled    - high in HOLD state (o_duty == target)
//   o_clamped    - last accepted setpoint exceeded DUTY_LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module hv_duty_ramp #(
  parameter logic [15:0] DUTY_DEFAULT  = 16'd819,
  parameter logic [15:0] DUTY_LIMIT    = 16'd900,
  parameter logic [15:0] STEP_SIZE     = 16'd8,
  parameter logic [31:0] STEP_INTERVAL = 32'd50_000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_hv_en,
  input  logic        i_set_valid,
  input  logic [15:0] i_set_duty,
  output logic        o_set_ready,
  output logic [15:0] o_duty,
  output logic        o_duty_valid,
  output logic        o_ramping,
  output logic        o_settled,
  output logic        o_clamped
);

  localparam logic        c_CLAMP_RST  = (DUTY_DEFAULT > DUTY_LIMIT);
  localparam logic [15:0] c_TARGET_RST = c_CLAMP_RST ? DUTY_LIMIT : DUTY_DEFAULT;
  localparam logic [31:0] c_TIMER_LAST = STEP_INTERVAL - 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_duty;
  logic [15:0] w_duty_nxt;
  logic [15:0] r_target;
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
  logic        r_clamped;
  logic        r_duty_valid;
  logic        r_ramping;
  logic        r_settled;

  logic        w_set_xfer;
  logic        w_set_over;
  logic [15:0] w_set_target;
  logic        w_up;
  logic [15:0] w_diff;
  logic [15:0] w_step;
  logic [15:0] w_stepped;

  // The stage never back-pressures the command path.
  assign o_set_ready  = 1'b1;
  assign w_set_xfer   = i_set_valid & o_set_ready;
  assign w_set_over   = (i_set_duty > DUTY_LIMIT);
  assign w_set_target = w_set_over ? DUTY_LIMIT : i_set_duty;

  // Direction chosen before subtracting, so the distance never wraps and the
  // step is trimmed to land exactly on the target.
  assign w_up      = (r_duty < r_target);
  assign w_diff    = w_up ? (r_target - r_duty) : (r_duty - r_target);
  assign w_step    = (w_diff < STEP_SIZE) ? w_diff : STEP_SIZE;
  assign w_stepped = w_up ? (r_duty + w_step) : (r_duty - w_step);

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        w_duty_nxt  = 16'd0;
        w_timer_nxt = 32'd0;
        if (i_hv_en) w_state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        if (!i_hv_en) begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = 16'd0;
          w_timer_nxt = 32'd0;
        end else if (r_duty == r_target) begin
          w_state_nxt = ST_HOLD;
          w_timer_nxt = 32'd0;
        end else if (r_timer == c_TIMER_LAST) begin
          // Uses the target registered before any same-cycle transfer.
          w_duty_nxt  = w_stepped;
          w_timer_nxt = 32'd0;
        end else begin
          w_timer_nxt = r_timer + 32'd1;
        end
      end
      ST_HOLD: begin
        w_timer_nxt = 32'd0;
        if (!i_hv_en) begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = 16'd0;
        end else if (r_target != r_duty) begin
          w_state_nxt = ST_RAMP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_duty_nxt  = 16'd0;
        w_timer_nxt = 32'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_duty       <= 16'd0;
      r_timer      <= 32'd0;
      r_target     <= c_TARGET_RST;
      r_clamped    <= c_CLAMP_RST;
      r_duty_valid <= 1'b0;
      r_ramping    <= 1'b0;
      r_settled    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_duty       <= w_duty_nxt;
      r_timer      <= w_timer_nxt;
      r_duty_valid <= (w_duty_nxt != r_duty);
      r_ramping    <= (w_state_nxt == ST_RAMP);
      r_settled    <= (w_state_nxt == ST_HOLD);
      if (w_set_xfer) begin
        r_target  <= w_set_target;
        r_clamped <= w_set_over;
      end
    end
  end

  assign o_duty       = r_duty;
  assign o_duty_valid = r_duty_valid;
  assign o_ramping    = r_ramping;
  assign o_settled    = r_settled;
  assign o_clamped    = r_clamped;

endmodule
`default_nettype wire

// File: tb/tb_hv_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_hv_duty_ramp
// Purpose  : Directed self-checking bench for hv_duty_ramp with
//            STEP_SIZE=8, STEP_INTERVAL=4, DUTY_LIMIT=900, DUTY_DEFAULT=819.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hv_duty_ramp;

  logic        clk;
  logic        i_rst_n;
  logic        i_hv_en;
  logic        i_set_valid;
  logic [15:0] i_set_duty;
  logic        o_set_ready;
  logic [15:0] o_duty;
  logic        o_duty_valid;
  logic        o_ramping;
  logic        o_settled;
  logic        o_clamped;

  int n_vec;
  int n_err;

  hv_duty_ramp #(
    .DUTY_DEFAULT (16'd819),
    .DUTY_LIMIT   (16'd900),
    .STEP_SIZE    (16'd8),
    .STEP_INTERVAL(32'd4)
  ) u_dut (
    .i_clk_50m   (clk),
    .i_rst_n     (i_rst_n),
    .i_hv_en     (i_hv_en),
    .i_set_valid (i_set_valid),
    .i_set_duty  (i_set_duty),
    .o_set_ready (o_set_ready),
    .o_duty      (o_duty),
    .o_duty_valid(o_duty_valid),
    .o_ramping   (o_ramping),
    .o_settled   (o_settled),
    .o_clamped   (o_clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [15:0] d);
    i_set_valid = 1'b1;
    i_set_duty  = d;
    tick();
    i_set_valid = 1'b0;
  endtask

  // Wait (bounded) for the next o_duty_valid pulse; check spacing and value.
  task automatic wait_step(input string tag, input int exp_duty, input int exp_gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_duty_valid && n < 20);
    chk({tag, "_gap"}, n, exp_gap);
    chk(tag, {16'd0, o_duty}, exp_duty);
  endtask

  // Independent step model: walk from 'from' toward 'to', stopping at 'stop'.
  task automatic ramp_to(input string tag, input int from, input int to,
                         input int stop, input int first_gap);
    int cur;
    int nxt;
    int gap;
    int guard;
    cur   = from;
    gap   = first_gap;
    guard = 0;
    while (cur != stop && guard < 200) begin
      if (cur < to) nxt = (to - cur < 8) ? to : cur + 8;
      else          nxt = (cur - to < 8) ? to : cur - 8;
      wait_step(tag, nxt, gap);
      chk({tag, "_ramping"}, o_ramping, 1);
      cur = nxt;
      gap = 4;
      guard++;
    end
    if (stop == to) begin
      tick();
      chk({tag, "_settled"}, o_settled, 1);
      chk({tag, "_not_ramping"}, o_ramping, 0);
      chk({tag, "_final"}, {16'd0, o_duty}, to);
    end
  endtask

  initial begin
    int cnt;
    n_vec       = 0;
    n_err       = 0;
    i_rst_n     = 1'b1;
    i_hv_en     = 1'b0;
    i_set_valid = 1'b0;
    i_set_duty  = 16'd0;

    // Reset state
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_duty", {16'd0, o_duty}, 0);
    chk("rst_valid", o_duty_valid, 0);
    chk("rst_ramping", o_ramping, 0);
    chk("rst_settled", o_settled, 0);
    chk("rst_ready", o_set_ready, 1);
    chk("rst_clamped", o_clamped, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_duty", {16'd0, o_duty}, 0);
    chk("idle_ready", o_set_ready, 1);

    // Soft start 0 -> 819
    i_hv_en = 1'b1;
    ramp_to("soft", 0, 819, 819, 5);

    // Clamp: 1000 -> 900
    xfer(16'd1000);
    chk("clamp_flag", o_clamped, 1);
    ramp_to("clamp", 819, 900, 900, 5);

    // Ramp down 900 -> 100
    xfer(16'd100);
    chk("down_clamp_clr", o_clamped, 0);
    ramp_to("down", 900, 100, 100, 5);

    // Back up, then ramp down and re-target to 500 at 404
    xfer(16'd900);
    ramp_to("up900", 100, 900, 900, 5);
    xfer(16'd100);
    ramp_to("rev", 900, 100, 404, 5);
    xfer(16'd500);
    wait_step("rev_turn", 412, 3);
    ramp_to("rev500", 412, 500, 500, 4);

    // HV drop from HOLD
    i_hv_en = 1'b0;
    tick();
    chk("hold_drop_duty", {16'd0, o_duty}, 0);
    chk("hold_drop_valid", o_duty_valid, 1);
    tick();
    chk("hold_drop_valid_end", o_duty_valid, 0);

    // HV drop mid-ramp at 400
    i_hv_en = 1'b1;
    ramp_to("hvrise", 0, 500, 400, 5);
    i_hv_en = 1'b0;
    tick();
    chk("drop_duty", {16'd0, o_duty}, 0);
    chk("drop_valid", o_duty_valid, 1);
    tick();
    chk("drop_valid_end", o_duty_valid, 0);
    chk("drop_ramping", o_ramping, 0);
    chk("drop_settled", o_settled, 0);
    chk("drop_duty_hold", {16'd0, o_duty}, 0);
    i_hv_en = 1'b1;
    ramp_to("restart", 0, 500, 500, 5);

    // No-op setpoint in HOLD at 819
    xfer(16'd819);
    ramp_to("up819", 500, 819, 819, 5);
    xfer(16'd819);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_duty_valid) cnt++;
    end
    chk("noop_pulses", cnt, 0);
    chk("noop_settled", o_settled, 1);
    chk("noop_duty", {16'd0, o_duty}, 819);

    // Back-to-back transfers: last one wins
    i_set_valid = 1'b1;
    i_set_duty  = 16'd819;
    tick();
    i_set_duty  = 16'd820;
    tick();
    i_set_valid = 1'b0;
    wait_step("b2b", 820, 5);
    tick();
    chk("b2b_settled", o_settled, 1);

    // Async reset mid-ramp
    xfer(16'd100);
    wait_step("pre_rst", 812, 5);
    wait_step("pre_rst", 804, 4);
    #3 i_rst_n = 1'b0;
    #1;
    chk("arst_duty", {16'd0, o_duty}, 0);
    chk("arst_valid", o_duty_valid, 0);
    chk("arst_ramping", o_ramping, 0);
    chk("arst_settled", o_settled, 0);
    chk("arst_ready", o_set_ready, 1);
    chk("arst_clamped", o_clamped, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    ramp_to("post_rst", 0, 819, 819, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
